// File: rtl/key_cond_pkg.sv
// Shared types and defaults for the pushbutton/switch input-conditioning stage.
package key_cond_pkg;

    typedef enum logic [1:0] {
        RELEASED,
        ARMING,
        PRESSED,
        DISARMING
    } key_state_t;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
    localparam int unsigned PRESS_CNT_W         = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input, with a selectable reset level.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/key_shift_capture.sv
// Debounces an active-low pushbutton and, once per accepted press, shifts the switch bit
// into the LED register, strobes the low nibble to the hex decoder and counts presses.
module key_shift_capture
    import key_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned WIDTH           = 10
) (
    input  logic                   CLOCK_50,
    input  logic                   Reset,
    input  logic                   KEY_n,
    input  logic                   SW_in,
    output logic [WIDTH-1:0]       data_out,
    output logic [3:0]             digit,
    output logic                   digit_valid,
    output logic [PRESS_CNT_W-1:0] press_count
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    logic             key_s;
    logic             sw_s;
    key_state_t       state;
    key_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             capture;

    sync2 #(.RST_VAL(1'b1)) u_key_sync (
        .clk (CLOCK_50),
        .rst (Reset),
        .d   (KEY_n),
        .q   (key_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sw_sync (
        .clk (CLOCK_50),
        .rst (Reset),
        .d   (SW_in),
        .q   (sw_s)
    );

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state <= RELEASED;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // cnt holds how many consecutive cycles the new level has been seen so far
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            RELEASED: begin
                if (!key_s) begin
                    state_next = ARMING;
                    cnt_next   = CNT_W'(1);
                end
            end
            ARMING: begin
                if (key_s) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (key_s) begin
                    state_next = DISARMING;
                    cnt_next   = CNT_W'(1);
                end
            end
            DISARMING: begin
                if (!key_s) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            data_out    <= '0;
            digit       <= '0;
            digit_valid <= 1'b0;
            press_count <= '0;
        end else begin
            digit_valid <= capture;
            if (capture) begin
                data_out    <= {data_out[WIDTH-2:0], sw_s};
                digit       <= {data_out[2:0], sw_s};
                press_count <= press_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_shift_capture.sv
// Randomised and directed bench for key_shift_capture against a run-length debounce model.
module tb_key_shift_capture;

    localparam int unsigned D = 4;
    localparam int unsigned W = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_n;
    logic         sw;
    logic [W-1:0] data_out;
    logic [3:0]   digit;
    logic         digit_valid;
    logic [7:0]   press_count;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit cmp_en = 1'b0;

    key_shift_capture #(
        .DEBOUNCE_CYCLES(D),
        .WIDTH          (W)
    ) dut (
        .CLOCK_50   (clk),
        .Reset      (rst),
        .KEY_n      (key_n),
        .SW_in      (sw),
        .data_out   (data_out),
        .digit      (digit),
        .digit_valid(digit_valid),
        .press_count(press_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the inputs reach the debouncer two edges late; a level is accepted
    // once the opposite level has been seen on D+1 consecutive edges.
    bit           h_key [2];
    bit           h_sw  [2];
    bit           pressed_lvl;
    int           run;
    logic [W-1:0] m_data;
    logic [3:0]   m_digit;
    bit           m_valid;
    int           m_count;

    always @(posedge clk or posedge rst) begin
        bit ks, ss;
        if (rst) begin
            h_key = '{1'b1, 1'b1};
            h_sw  = '{1'b0, 1'b0};
            pressed_lvl = 1'b0;
            run     = 0;
            m_data  = '0;
            m_digit = '0;
            m_valid = 1'b0;
            m_count = 0;
        end else begin
            ks = h_key[1];
            ss = h_sw[1];
            h_key[1] = h_key[0]; h_key[0] = key_n;
            h_sw[1]  = h_sw[0];  h_sw[0]  = sw;
            m_valid = 1'b0;
            if ((ks == 1'b0) != pressed_lvl) begin
                run++;
                if (run == D + 1) begin
                    run = 0;
                    pressed_lvl = !pressed_lvl;
                    if (pressed_lvl) begin
                        m_data  = (m_data << 1) | W'(ss);
                        m_digit = m_data[3:0];
                        m_valid = 1'b1;
                        m_count = (m_count + 1) % 256;
                    end
                end
            end else begin
                run = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (digit_valid === 1'b1) pulses++;
        if (cmp_en) begin
            chk("model_data_out",    32'(data_out),    32'(m_data));
            chk("model_digit",       32'(digit),       32'(m_digit));
            chk("model_digit_valid", 32'(digit_valid), 32'(m_valid));
            chk("model_press_count", 32'(press_count), m_count);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; the first posedge afterwards is edge 0 of the press.
    task automatic press(input logic s, input int low, input int high);
        int lat;
        lat = -1;
        sw = s;
        key_n = 1'b0;
        for (int k = 0; k < low; k++) begin
            @(negedge clk);
            if (digit_valid === 1'b1 && lat < 0) lat = k;
        end
        key_n = 1'b1;
        cyc(high);
        chk("press_latency", lat, D + 2);
    endtask

    task automatic reset_mid_clock();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_data_out",    32'(data_out),    0);
        chk("async_rst_digit",       32'(digit),       0);
        chk("async_rst_digit_valid", 32'(digit_valid), 0);
        chk("async_rst_press_count", 32'(press_count), 0);
    endtask

    initial begin
        int p0, lat;
        rst = 1'b1;
        key_n = 1'b1;
        sw = 1'b1;
        cyc(3);
        cmp_en = 1'b1;
        chk("reset_data_out",    32'(data_out),    0);
        chk("reset_press_count", 32'(press_count), 0);
        rst = 1'b0;
        cyc(4);

        // single press held for 12 cycles
        p0 = pulses;
        press(1'b1, 12, 12);
        chk("press1_data_out", 32'(data_out),    32'h001);
        chk("press1_digit",    32'(digit),       32'h1);
        chk("press1_count",    32'(press_count), 1);
        chk("press1_pulses",   pulses - p0,      1);

        // asynchronous reset mid-clock, then quiet period
        reset_mid_clock();
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        cyc(20);
        chk("post_reset_pulses", pulses - p0, 0);

        // press bounce too short to be accepted
        p0 = pulses;
        key_n = 1'b0; cyc(3);
        key_n = 1'b1; cyc(1);
        key_n = 1'b0; cyc(3);
        key_n = 1'b1; cyc(1);
        cyc(12);
        chk("bounce_pulses",   pulses - p0,    0);
        chk("bounce_data_out", 32'(data_out),  0);

        press(1'b1, 8, 8);
        press(1'b0, 8, 8);
        press(1'b1, 8, 8);
        press(1'b1, 8, 8);
        chk("four_data_out", 32'(data_out),    32'h00B);
        chk("four_digit",    32'(digit),       32'hB);
        chk("four_count",    32'(press_count), 4);
        for (int i = 0; i < 11; i++) press(1'b1, 8, 8);
        chk("fill_data_out", 32'(data_out),    32'h3FF);
        chk("fill_count",    32'(press_count), 15);

        // release bounce while pressed
        p0 = pulses;
        sw = 1'b0;
        key_n = 1'b0; cyc(12);
        key_n = 1'b1; cyc(2);
        key_n = 1'b0; cyc(5);
        key_n = 1'b1; cyc(12);
        chk("rel_bounce_pulses", pulses - p0,      1);
        chk("rel_bounce_count",  32'(press_count), 16);
        chk("rel_bounce_data",   32'(data_out),    32'h3FE);

        // reset while arming with the key held through release
        key_n = 1'b0;
        cyc(4);
        reset_mid_clock();
        @(negedge clk);
        rst = 1'b0;
        lat = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (digit_valid === 1'b1 && lat < 0) lat = k;
        end
        key_n = 1'b1;
        cyc(10);
        chk("rst_arming_latency", lat, D + 2);
        chk("rst_arming_count",   32'(press_count), 1);

        // counter wrap
        reset_mid_clock();
        @(negedge clk);
        rst = 1'b0;
        p0 = pulses;
        for (int i = 0; i < 256; i++) press(1'(i % 3 == 0), 8, 8);
        chk("wrap_pulses", pulses - p0,      256);
        chk("wrap_count",  32'(press_count), 0);

        // randomised key/switch activity with occasional resets
        for (int seg = 0; seg < 400; seg++) begin
            int hold;
            key_n = 1'($urandom_range(0, 1));
            hold  = int'($urandom_range(1, 12));
            for (int c = 0; c < hold; c++) begin
                sw = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            if ($urandom_range(0, 59) == 0) begin
                #2 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        key_n = 1'b1;
        cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_shift_capture.md
Name: key_shift_capture

Overview:
- Input-conditioning stage that sits directly upstream of the display stage on the DE-series board.
- Synchronises and debounces a raw active-low pushbutton and produces a clean single press event.
- On each press, shifts the current switch bit into a 10-bit register driving the LEDs.
- Presents the low nibble as a hex digit with a one-cycle valid strobe for the seven-segment decoder, and keeps a press counter.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 1..2^20-1.
- WIDTH, 10, shift register width (matches LEDR); minimum 4.

Ports:
- CLOCK_50  input  1  system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-high reset.
- KEY_n  input  1  raw pushbutton, active-low (0 = pressed), asynchronous to CLOCK_50.
- SW_in  input  1  raw switch bit to capture, asynchronous.
- data_out  output  WIDTH  shift register contents (to LEDR).
- digit  output  4  equals data_out[3:0] after each capture (to hex decoder).
- digit_valid  output  1  one-cycle strobe, high in the cycle in which data_out and digit first show the new value.
- press_count  output  8  number of accepted presses, modulo 256.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - data_out=0, digit=0, digit_valid=0, press_count=0, FSM=RELEASED, debounce counter=0.
  - KEY_n synchroniser flops reset to 1 (released); SW_in synchroniser flops reset to 0.
- Synchronisation: two-flop synchroniser on each of KEY_n and SW_in. key_s and sw_s are the second-stage outputs.
- Debounce FSM, four states:
  - RELEASED: if key_s==0, go to ARMING and set cnt=1; otherwise stay.
  - ARMING: if key_s==1, return to RELEASED with cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to PRESSED and perform a capture. Else cnt++.
  - PRESSED: if key_s==1, go to DISARMING and set cnt=1; otherwise stay.
  - DISARMING: if key_s==0, return to PRESSED with cnt=0. Else if cnt==DEBOUNCE_CYCLES, go to RELEASED. Else cnt++.
- Capture, on the same edge that enters PRESSED:
  - data_out <= {data_out[WIDTH-2:0], sw_s}; the MSB is discarded.
  - digit <= {data_out[2:0], sw_s}.
  - press_count <= press_count+1, wrapping 255 to 0.
  - digit_valid <= 1 for exactly one cycle, then 0.
- Latency: KEY_n falls and stays low → digit_valid high after the (DEBOUNCE_CYCLES+2)th rising edge, counting from the first edge that samples KEY_n=0. The +2 is the synchroniser.
- Bounce rules:
  - Any bounce shorter than DEBOUNCE_CYCLES in ARMING produces no capture.
  - Any bounce in PRESSED or DISARMING shorter than DEBOUNCE_CYCLES produces no second capture.
  - Exactly one capture per accepted press, however long the key is held.
- SW sampling: the value captured is sw_s at the capture edge. SW toggles at any other time have no effect.
- Reset mid-operation: everything returns to reset values immediately, including in ARMING. If KEY_n is held low through reset release, it counts as a new press, with capture at edge DEBOUNCE_CYCLES+2 after release.
- DEBOUNCE_CYCLES==1: ARMING lasts exactly one cycle; capture occurs on the edge after entering ARMING.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never exceeds DEBOUNCE_CYCLES.

Decomposition:
- Package key_cond_pkg:
  - enum typedef key_state_t {RELEASED, ARMING, PRESSED, DISARMING}.
  - localparam DEF_DEBOUNCE_CYCLES=500000.
  - localparam PRESS_CNT_W=8.
- Sub-module sync2 (parameterised reset value RST_VAL), instantiated twice: once for KEY_n with RST_VAL=1, once for SW_in with RST_VAL=0.
- The FSM, debounce counter and shift register stay in key_shift_capture.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=10):
- Reset asserted mid-clock, with KEY_n=1 and SW_in=1 → all outputs 0 immediately (asynchronous); no digit_valid during the 20 cycles after release.
- SW_in=1, KEY_n low for 12 cycles then high → one digit_valid pulse at edge 6 after the fall; data_out=10'h001, digit=4'h1, press_count=1; no further pulse after release.
- Bounce: KEY_n low 3 cycles, high 1, low 3, high 1, then high → no digit_valid, data_out unchanged, FSM returns to RELEASED.
- Four clean presses with SW=1,0,1,1 → data_out=10'h00B, digit=4'hB, press_count=4. Continue to 11 presses with SW=1 each → data_out=10'h3FF, and the original MSB is shifted out.
- Release bounce: while in PRESSED, KEY_n high 2 cycles then low 5 cycles, then clean release → no second capture, press_count unchanged. Separately, assert Reset during ARMING with KEY_n held low → outputs 0; capture at edge 6 after reset release, press_count=1.
- 256 clean presses → press_count wraps to 0 and digit_valid pulses exactly 256 times.
